// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frames 16-bit receiver words into sync/checksum-checked packets, buffers the
// payload for the consumer, and applies in-band SET_BAUD updates to the receiver bit period.
module uart_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DEFAULT_CPB    = 217
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_DV,
  input  logic [15:0] i_Rx_Word,
  output logic [7:0]  o_Clks_Per_Bit,
  output logic        o_Pkt_Valid,
  output logic [3:0]  o_Pkt_Cmd,
  output logic [3:0]  o_Pkt_Len,
  output logic [15:0] o_Rd_Data,
  input  logic        i_Rd_En,
  input  logic        i_Pkt_Done,
  output logic        o_Err,
  output logic [2:0]  o_Err_Code
);
  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]    CMD_SET_BAUD = 4'd1;
  localparam logic [2:0]    E_SYNC       = 3'd1;
  localparam logic [2:0]    E_CSUM       = 3'd2;
  localparam logic [2:0]    E_TMO        = 3'd3;
  localparam logic [2:0]    E_OVR        = 3'd4;
  localparam logic [2:0]    E_BAUD       = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    rd_ptr_q, rd_ptr_d;
  logic [15:0]   csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cpb_q, cpb_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;
  logic [15:0]   buf_q [16];
  logic          buf_we;
  logic          waiting;

  assign waiting = ((state_q == S_PAYLOAD) || (state_q == S_CHECK)) && !i_Rx_DV;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    idx_d    = idx_q;
    rd_ptr_d = rd_ptr_q;
    csum_d   = csum_q;
    tmo_d    = '0;
    cpb_d    = cpb_q;
    err_d    = 1'b0;
    code_d   = code_q;
    buf_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV) begin
          if (i_Rx_Word[15:12] != 4'hA) begin
            err_d  = 1'b1;
            code_d = E_SYNC;
          end else begin
            cmd_d   = i_Rx_Word[11:8];
            len_d   = i_Rx_Word[3:0];
            csum_d  = i_Rx_Word;
            idx_d   = '0;
            state_d = (i_Rx_Word[3:0] == 4'd0) ? S_CHECK : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ i_Rx_Word;
          idx_d  = idx_q + 4'd1;
          if (idx_q + 4'd1 == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (i_Rx_DV) begin
          state_d = S_IDLE;
          if (i_Rx_Word != csum_q) begin
            err_d  = 1'b1;
            code_d = E_CSUM;
          end else if (cmd_q == CMD_SET_BAUD) begin
            // SET_BAUD is consumed here and never reaches the consumer.
            if ((len_q == 4'd1) && (buf_q[0][7:0] >= 8'd4)) begin
              cpb_d = buf_q[0][7:0];
            end else begin
              err_d  = 1'b1;
              code_d = E_BAUD;
            end
          end else begin
            state_d  = S_HOLD;
            rd_ptr_d = '0;
          end
        end
      end
      S_HOLD: begin
        if (i_Rd_En && (rd_ptr_q < len_q)) rd_ptr_d = rd_ptr_q + 4'd1;
        if (i_Pkt_Done) state_d = S_IDLE;
        if (i_Rx_DV) begin
          err_d  = 1'b1;
          code_d = E_OVR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A word arriving on the expiry cycle is accepted instead of timing out.
    if (waiting) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        code_d  = E_TMO;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      rd_ptr_q <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      cpb_q    <= 8'(DEFAULT_CPB);
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rd_ptr_q <= rd_ptr_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      cpb_q    <= cpb_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (buf_we) buf_q[idx_q] <= i_Rx_Word;
  end

  assign o_Clks_Per_Bit = cpb_q;
  assign o_Pkt_Valid    = (state_q == S_HOLD);
  assign o_Pkt_Cmd      = cmd_q;
  assign o_Pkt_Len      = len_q;
  assign o_Rd_Data      = (rd_ptr_q < len_q) ? buf_q[rd_ptr_q] : 16'h0000;
  assign o_Err          = err_q;
  assign o_Err_Code     = code_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized packets checked against a
// packet-level reference model (checksum by XOR over the payload queue).
module tb_uart_rx_ctrl;
  localparam int TMO  = 100;
  localparam int DCPB = 217;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [15:0] rx_word = 16'h0000;
  logic        rd_en = 1'b0;
  logic        pkt_done = 1'b0;
  logic [7:0]  cpb;
  logic        pkt_valid;
  logic [3:0]  pkt_cmd;
  logic [3:0]  pkt_len;
  logic [15:0] rd_data;
  logic        err;
  logic [2:0]  err_code;

  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  logic [7:0]  exp_cpb = 8'(DCPB);
  logic [15:0] pl_q[$];

  uart_rx_ctrl #(.TIMEOUT_CYCLES(TMO), .DEFAULT_CPB(DCPB)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Word(rx_word),
    .o_Clks_Per_Bit(cpb), .o_Pkt_Valid(pkt_valid), .o_Pkt_Cmd(pkt_cmd), .o_Pkt_Len(pkt_len),
    .o_Rd_Data(rd_data), .i_Rd_En(rd_en), .i_Pkt_Done(pkt_done),
    .o_Err(err), .o_Err_Code(err_code)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (err) err_seen++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    rx_dv = 1'b1;
    rx_word = w;
    @(negedge clk);
    rx_dv = 1'b0;
    rx_word = 16'($urandom);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_done();
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] hdr);
    logic [15:0] c;
    c = hdr;
    foreach (pl_q[i]) c = c ^ pl_q[i];
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    checks++; if (cpb !== 8'(DCPB)) begin errors++; $display("FAIL reset_cpb got %0d exp %0d", cpb, DCPB); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", pkt_valid); end
    checks++; if (pkt_cmd !== 4'd0) begin errors++; $display("FAIL reset_cmd got %h exp 0", pkt_cmd); end
    checks++; if (pkt_len !== 4'd0) begin errors++; $display("FAIL reset_len got %h exp 0", pkt_len); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", err_code); end
    rst_n = 1'b1;
    idle(2);
    checks++; if (pkt_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL post_reset_idle valid %b err %b exp 0 0", pkt_valid, err); end
  endtask

  task automatic test_good_packet();
    send_word(16'hA202); send_word(16'h1234); send_word(16'h5678); send_word(16'hE64E);
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b exp 1", pkt_valid); end
    checks++; if (pkt_cmd !== 4'd2) begin errors++; $display("FAIL good_cmd got %h exp 2", pkt_cmd); end
    checks++; if (pkt_len !== 4'd2) begin errors++; $display("FAIL good_len got %h exp 2", pkt_len); end
    checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL good_rd0 got %h exp 1234", rd_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_no_err got %b exp 0", err); end
    pulse_rd();
    checks++; if (rd_data !== 16'h5678) begin errors++; $display("FAIL good_rd1 got %h exp 5678", rd_data); end
    pulse_rd();
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL good_rd_past got %h exp 0000", rd_data); end
    pulse_rd();
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL good_rd_sat got %h exp 0000", rd_data); end
    pulse_done();
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL good_release got %b exp 0", pkt_valid); end
  endtask

  task automatic test_errors();
    send_word(16'hA202); send_word(16'h1234); send_word(16'h5678); send_word(16'hE64F);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_err got %b exp 1", err); end
    checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL csum_code got %0d exp 2", err_code); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL csum_valid got %b exp 0", pkt_valid); end
    idle(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b exp 0", err); end
    checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL code_hold got %0d exp 2", err_code); end
    send_word(16'h5202);
    checks++; if (err !== 1'b1 || err_code !== 3'd1) begin errors++; $display("FAIL sync_err got err %b code %0d exp 1 1", err, err_code); end
  endtask

  task automatic test_set_baud();
    send_word(16'hA101); send_word(16'h0064); send_word(16'hA165);
    exp_cpb = 8'd100;
    checks++; if (cpb !== 8'd100) begin errors++; $display("FAIL baud_set got %0d exp 100", cpb); end
    checks++; if (pkt_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL baud_quiet valid %b err %b exp 0 0", pkt_valid, err); end
    send_word(16'hA101); send_word(16'h0003); send_word(16'hA102);
    checks++; if (err !== 1'b1 || err_code !== 3'd5) begin errors++; $display("FAIL baud_low got err %b code %0d exp 1 5", err, err_code); end
    checks++; if (cpb !== 8'd100) begin errors++; $display("FAIL baud_keep got %0d exp 100", cpb); end
    send_word(16'hA102); send_word(16'h0010); send_word(16'h0020); send_word(16'hA132);
    checks++; if (err !== 1'b1 || err_code !== 3'd5 || cpb !== 8'd100) begin errors++; $display("FAIL baud_len2 got err %b code %0d cpb %0d exp 1 5 100", err, err_code, cpb); end
  endtask

  task automatic test_timeout();
    int found;
    found = -1;
    send_word(16'hA202); send_word(16'h1234);
    for (int i = 0; i < 2 * TMO && found < 0; i++) begin
      if (err) found = i;
      else @(negedge clk);
    end
    checks++; if (found != TMO - 1) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", found, TMO - 1); end
    checks++; if (err_code !== 3'd3) begin errors++; $display("FAIL tmo_code got %0d exp 3", err_code); end
    send_word(16'hA000); send_word(16'hA000);
    checks++; if (pkt_valid !== 1'b1 || pkt_len !== 4'd0 || rd_data !== 16'h0) begin errors++; $display("FAIL tmo_recover valid %b len %0d rd %h exp 1 0 0000", pkt_valid, pkt_len, rd_data); end
    pulse_done();
    // Word lands on the very cycle the counter would expire.
    send_word(16'hA202); send_word(16'h1234);
    idle(TMO - 2);
    send_word(16'h5678);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_word_wins err got %b exp 0", err); end
    send_word(16'hE64E);
    checks++; if (pkt_valid !== 1'b1 || rd_data !== 16'h1234) begin errors++; $display("FAIL tmo_word_wins_pkt valid %b rd %h exp 1 1234", pkt_valid, rd_data); end
    pulse_done();
  endtask

  task automatic test_overrun();
    logic [15:0] p [3];
    logic [15:0] c;
    c = 16'hA303;
    for (int i = 0; i < 3; i++) begin p[i] = 16'($urandom); c = c ^ p[i]; end
    send_word(16'hA303); send_word(p[0]); send_word(p[1]); send_word(p[2]); send_word(c);
    checks++; if (pkt_valid !== 1'b1 || rd_data !== p[0]) begin errors++; $display("FAIL ovr_hold valid %b rd %h exp 1 %h", pkt_valid, rd_data, p[0]); end
    pulse_rd();
    send_word(16'h1111);
    checks++; if (err !== 1'b1 || err_code !== 3'd4) begin errors++; $display("FAIL ovr_err got err %b code %0d exp 1 4", err, err_code); end
    checks++; if (pkt_valid !== 1'b1 || rd_data !== p[1]) begin errors++; $display("FAIL ovr_intact valid %b rd %h exp 1 %h", pkt_valid, rd_data, p[1]); end
    pulse_rd();
    checks++; if (rd_data !== p[2]) begin errors++; $display("FAIL ovr_rd2 got %h exp %h", rd_data, p[2]); end
    rx_dv = 1'b1; rx_word = 16'h1111; pkt_done = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0; pkt_done = 1'b0;
    checks++; if (err !== 1'b1 || err_code !== 3'd4) begin errors++; $display("FAIL ovr_done_err got err %b code %0d exp 1 4", err, err_code); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL ovr_done_release got %b exp 0", pkt_valid); end
    idle(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_pulse_width got %b exp 0", err); end
    send_word(16'hA000); send_word(16'hA000);
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL ovr_then_idle got %b exp 1", pkt_valid); end
    pulse_done();
  endtask

  task automatic test_reset_mid();
    send_word(16'hA202);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cpb !== 8'(DCPB)) begin errors++; $display("FAIL rstmid_cpb got %0d exp %0d", cpb, DCPB); end
    checks++; if (err_code !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_err got err %b code %0d exp 0 0", err, err_code); end
    checks++; if (pkt_valid !== 1'b0 || pkt_cmd !== 4'd0 || pkt_len !== 4'd0) begin errors++; $display("FAIL rstmid_pkt valid %b cmd %h len %h exp 0 0 0", pkt_valid, pkt_cmd, pkt_len); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cpb = 8'(DCPB);
    @(negedge clk);
    send_word(16'hA202); send_word(16'h1234); send_word(16'h5678); send_word(16'hE64E);
    checks++; if (pkt_valid !== 1'b1 || rd_data !== 16'h1234 || err !== 1'b0) begin errors++; $display("FAIL rstmid_after valid %b rd %h err %b exp 1 1234 0", pkt_valid, rd_data, err); end
    pulse_done();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          kind;
      int          snap;
      int          exp_code;
      bit          exp_hold;
      bit          corrupt;
      logic [3:0]  cmd;
      logic [3:0]  len;
      logic [15:0] hdr;
      logic [15:0] cks;
      logic [15:0] w;
      logic [15:0] w0;
      kind = $urandom_range(0, 9);
      exp_code = 0;
      exp_hold = 1'b0;
      #1 snap = err_seen;
      if (kind == 0) begin
        hdr = {4'($urandom_range(0, 9)), 12'($urandom)};
        send_word(hdr);
        exp_code = 1;
        checks++; if (err !== 1'b1 || err_code !== 3'd1 || pkt_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d sync got err %b code %0d valid %b exp 1 1 0", n, err, err_code, pkt_valid); end
      end else begin
        cmd = (kind <= 2) ? 4'd1 : 4'($urandom_range(0, 15));
        if (cmd == 4'd1) len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd1;
        else len = 4'($urandom_range(0, 15));
        pl_q.delete();
        for (int i = 0; i < int'(len); i++) begin
          w = 16'($urandom);
          if (i == 0 && cmd == 4'd1 && $urandom_range(0, 2) == 0) w[7:0] = 8'($urandom_range(0, 7));
          pl_q.push_back(w);
        end
        w0 = (pl_q.size() > 0) ? pl_q[0] : 16'h0;
        hdr = {4'hA, cmd, 4'($urandom), len};
        corrupt = ($urandom_range(0, 5) == 0);
        cks = model_csum(hdr);
        if (corrupt) cks = cks ^ (16'd1 << $urandom_range(0, 15));
        send_word(hdr);
        foreach (pl_q[i]) begin idle($urandom_range(0, 3)); send_word(pl_q[i]); end
        idle($urandom_range(0, 3));
        send_word(cks);
        if (corrupt) exp_code = 2;
        else if (cmd == 4'd1) begin
          if (len == 4'd1 && w0[7:0] >= 8'd4) exp_cpb = w0[7:0];
          else exp_code = 5;
        end else exp_hold = 1'b1;
        checks++; if (err !== (exp_code != 0)) begin errors++; $display("FAIL rnd%0d err got %b exp %b", n, err, exp_code != 0); end
        if (exp_code != 0) begin
          checks++; if (err_code !== 3'(exp_code)) begin errors++; $display("FAIL rnd%0d code got %0d exp %0d", n, err_code, exp_code); end
        end
        checks++; if (pkt_valid !== exp_hold) begin errors++; $display("FAIL rnd%0d valid got %b exp %b", n, pkt_valid, exp_hold); end
        checks++; if (cpb !== exp_cpb) begin errors++; $display("FAIL rnd%0d cpb got %0d exp %0d", n, cpb, exp_cpb); end
        if (exp_hold) begin
          checks++; if (pkt_cmd !== cmd || pkt_len !== len) begin errors++; $display("FAIL rnd%0d hdr got cmd %h len %h exp %h %h", n, pkt_cmd, pkt_len, cmd, len); end
          foreach (pl_q[i]) begin
            checks++; if (rd_data !== pl_q[i]) begin errors++; $display("FAIL rnd%0d rd[%0d] got %h exp %h", n, i, rd_data, pl_q[i]); end
            pulse_rd();
          end
          checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rnd%0d rd_end got %h exp 0000", n, rd_data); end
          pulse_done();
          checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d release got %b exp 0", n, pkt_valid); end
        end
      end
      idle(1);
      #1;
      checks++; if (err_seen - snap != ((exp_code != 0) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d err_pulses got %0d exp %0d", n, err_seen - snap, (exp_code != 0) ? 1 : 0); end
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_errors();
    test_set_baud();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
